// File: rtl/pow2_decomposer.sv
// Streams the set bits of a W-bit count as power-of-two exponents, one beat per cycle.
// Optional build macro POW2_DECOMP_LSB_FIRST_EN selects LSB-first beat order (default MSB-first).
module pow2_decomposer #(
    parameter  int unsigned W     = 5,
    localparam int unsigned EXP_W = $clog2(W),
    localparam int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     num_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [EXP_W-1:0] n_o,
    output logic [W-1:0]     m_o,
    output logic [CNT_W-1:0] idx_o,
    output logic             last_o,
    output logic             zero_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             zflag_q, zflag_d;

    logic [EXP_W-1:0] n_c;
    logic [W-1:0]     mask_c;
    logic [W-1:0]     m_c;
    logic             last_c;
    logic             in_ready_c;
    logic             accept_c;

    // Priority encoder on the registered remainder; mask is the one-hot bit being removed.
    always_comb begin
        n_c    = '0;
        mask_c = '0;
`ifdef POW2_DECOMP_LSB_FIRST_EN
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                n_c    = EXP_W'(i);
                mask_c = W'(1) << i;
            end
        end
`else
        for (int i = 0; i < int'(W); i++) begin
            if (rem_q[i]) begin
                n_c    = EXP_W'(i);
                mask_c = W'(1) << i;
            end
        end
`endif
    end

    assign m_c    = rem_q & ~mask_c;
    assign last_c = (m_c == '0);

    // Ready also opens on the final consumed beat so values stream without a bubble.
    assign in_ready_c = (state_q == IDLE) || (last_c && out_ready_i);
    assign accept_c   = in_valid_i && in_ready_c;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            zflag_q <= zflag_d;
        end
    end

    // Next-state logic; returning to IDLE clears the datapath so idle outputs match reset.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        zflag_d = zflag_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rem_d   = num_i;
                    idx_d   = '0;
                    zflag_d = (num_i == '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_ready_i) begin
                    if (!last_c) begin
                        rem_d = m_c;
                        idx_d = idx_q + CNT_W'(1);
                    end else if (accept_c) begin
                        rem_d   = num_i;
                        idx_d   = '0;
                        zflag_d = (num_i == '0);
                    end else begin
                        rem_d   = '0;
                        idx_d   = '0;
                        zflag_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = in_ready_c;
    assign out_valid_o = (state_q == BUSY);
    assign n_o         = n_c;
    assign m_o         = m_c;
    assign idx_o       = idx_q;
    assign last_o      = last_c;
    assign zero_o      = zflag_q;

endmodule

// File: tb/tb_pow2_decomposer.sv
// Directed bench for pow2_decomposer: W=5 instance for most cases, W=8 instance for the wide case.
module tb_pow2_decomposer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, last, zero;
    logic [4:0] num, m;
    logic [2:0] n, idx;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, last8, zero8;
    logic [7:0] num8, m8;
    logic [2:0] n8;
    logic [3:0] idx8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pow2_decomposer #(.W(5)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .num_i(num), .out_valid_o(out_valid), .out_ready_i(out_ready), .n_o(n),
        .m_o(m), .idx_o(idx), .last_o(last), .zero_o(zero)
    );

    pow2_decomposer #(.W(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .num_i(num8), .out_valid_o(out_valid8), .out_ready_i(out_ready8), .n_o(n8),
        .m_o(m8), .idx_o(idx8), .last_o(last8), .zero_o(zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int en, input int em, input int ei,
                              input int el, input int ez);
        check({tag, ".valid"}, 32'(out_valid), 32'(1));
        check({tag, ".n"},     32'(n),     32'(en));
        check({tag, ".m"},     32'(m),     32'(em));
        check({tag, ".idx"},   32'(idx),   32'(ei));
        check({tag, ".last"},  32'(last),  32'(el));
        check({tag, ".zero"},  32'(zero),  32'(ez));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(0));
        check({tag, ".ready"}, 32'(in_ready),  32'(1));
        check({tag, ".n"},     32'(n),     32'(0));
        check({tag, ".m"},     32'(m),     32'(0));
        check({tag, ".idx"},   32'(idx),   32'(0));
        check({tag, ".last"},  32'(last),  32'(1));
        check({tag, ".zero"},  32'(zero),  32'(0));
    endtask

    task automatic check_beat8(input string tag, input int en, input int em, input int ei,
                               input int el);
        check({tag, ".valid"}, 32'(out_valid8), 32'(1));
        check({tag, ".n"},     32'(n8),    32'(en));
        check({tag, ".m"},     32'(m8),    32'(em));
        check({tag, ".idx"},   32'(idx8),  32'(ei));
        check({tag, ".last"},  32'(last8), 32'(el));
        check({tag, ".zero"},  32'(zero8), 32'(0));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int exp_n31 [5];
        int exp_m31 [5];
        int rdy_pat [8];
        int k;
`ifdef POW2_DECOMP_LSB_FIRST_EN
        exp_n31 = '{0, 1, 2, 3, 4};
        exp_m31 = '{30, 28, 24, 16, 0};
`else
        exp_n31 = '{4, 3, 2, 1, 0};
        exp_m31 = '{15, 7, 3, 1, 0};
`endif
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1, 1};

        rst_n = 1'b0; in_valid = 1'b0; num = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; num8 = '0; out_ready8 = 1'b1;
        step(); step();
        check_idle("reset");
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        // 22 = 10110
        in_valid = 1'b1; num = 5'd22;
        step();
        in_valid = 1'b0; num = '0;
`ifdef POW2_DECOMP_LSB_FIRST_EN
        check_beat("v22.b0", 1, 20, 0, 0, 0); step();
        check_beat("v22.b1", 2, 16, 1, 0, 0); step();
        check_beat("v22.b2", 4, 0, 2, 1, 0);
`else
        check_beat("v22.b0", 4, 6, 0, 0, 0); step();
        check_beat("v22.b1", 2, 2, 1, 0, 0); step();
        check_beat("v22.b2", 1, 0, 2, 1, 0);
`endif
        check("v22.b2.in_ready", 32'(in_ready), 32'(1));
        step();
        check_idle("v22.idle");

        // Zero then one, back to back
        in_valid = 1'b1; num = 5'd0;
        step();
        check_beat("v0", 0, 0, 0, 1, 1);
        num = 5'd1;
        step();
        in_valid = 1'b0; num = '0;
        check_beat("v1", 0, 0, 0, 1, 0);
        step();
        check_idle("v1.idle");

        // 31 with a stalling consumer
        in_valid = 1'b1; num = 5'd31;
        step();
        in_valid = 1'b0; num = '0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            check_beat($sformatf("v31.c%0d", c), exp_n31[k], exp_m31[k], k, (k == 4) ? 1 : 0, 0);
            out_ready = 1'(rdy_pat[c]);
            #1;
            check($sformatf("v31.c%0d.in_ready", c), 32'(in_ready),
                  32'((k == 4 && rdy_pat[c] == 1) ? 1 : 0));
            step();
            if (rdy_pat[c] == 1) k++;
        end
        check("v31.beats", 32'(k), 32'(5));
        check_idle("v31.idle");

        // 9 then 16 with in_valid held high
        out_ready = 1'b1;
        in_valid = 1'b1; num = 5'd9;
        step();
`ifdef POW2_DECOMP_LSB_FIRST_EN
        check_beat("v9.b0", 0, 8, 0, 0, 0);
`else
        check_beat("v9.b0", 3, 1, 0, 0, 0);
`endif
        check("v9.b0.in_ready", 32'(in_ready), 32'(0));
        num = 5'd16;
        step();
`ifdef POW2_DECOMP_LSB_FIRST_EN
        check_beat("v9.b1", 3, 0, 1, 1, 0);
`else
        check_beat("v9.b1", 0, 0, 1, 1, 0);
`endif
        check("v9.b1.in_ready", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0; num = '0;
        check_beat("v16.b0", 4, 0, 0, 1, 0);
        step();
        check_idle("v16.idle");

        // Reset in the middle of a value
        in_valid = 1'b1; num = 5'd31;
        step();
        in_valid = 1'b0; num = '0;
        step(); step();
        check_beat("rst.b2", exp_n31[2], exp_m31[2], 2, 0, 0);
        rst_n = 1'b0;
        step();
        check_idle("rst.dropped");
        rst_n = 1'b1;
        in_valid = 1'b1; num = 5'd3;
        step();
        in_valid = 1'b0; num = '0;
`ifdef POW2_DECOMP_LSB_FIRST_EN
        check_beat("v3.b0", 0, 2, 0, 0, 0); step();
        check_beat("v3.b1", 1, 0, 1, 1, 0);
`else
        check_beat("v3.b0", 1, 1, 0, 0, 0); step();
        check_beat("v3.b1", 0, 0, 1, 1, 0);
`endif
        step();
        check_idle("v3.idle");

        // Wide instance: 200 = 11001000
        in_valid8 = 1'b1; num8 = 8'd200;
        step();
        in_valid8 = 1'b0; num8 = '0;
`ifdef POW2_DECOMP_LSB_FIRST_EN
        check_beat8("w200.b0", 3, 192, 0, 0); step();
        check_beat8("w200.b1", 6, 128, 1, 0); step();
        check_beat8("w200.b2", 7, 0, 2, 1);
`else
        check_beat8("w200.b0", 7, 72, 0, 0); step();
        check_beat8("w200.b1", 6, 8, 1, 0); step();
        check_beat8("w200.b2", 3, 0, 2, 1);
`endif
        step();
        check("w200.idle.valid", 32'(out_valid8), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
